// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmitter slice.
//   DATA_BITS  : payload bits per frame (LSB first on the line)
//   FRAME_BITS : line bits per frame, start + data (+ parity) + stop
//   state_t    : transmitter FSM state encoding and its constants
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit and
// the ST_PARITY state; without it the frame is plain 8N1.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam state_t ST_PARITY = 3'd4;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen -- bit-period counter for the UART transmitter.
// Ports:
//   clk           : rising-edge clock
//   rst_n         : asynchronous active-low reset
//   en            : count while high; held low the counter sits at 0, so the
//                   first period after enable rising is a full DIV cycles
//   tick          : one-cycle pulse on the last cycle of each bit period
//   chipscope_clk : debug square wave toggling at every period wrap, 0 when
//                   disabled
module uart_baud_gen #(
  parameter int unsigned DIV = 13020
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick,
  output logic chipscope_clk
);

  localparam int unsigned CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] cnt;
  logic             cs_q;

  assign tick          = en && (cnt == CNT_W'(DIV - 1));
  // Masked so the debug clock reads 0 on the idle cycle after a frame even
  // when an odd number of periods left the toggle register high.
  assign chipscope_clk = cs_q & en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      cs_q <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      cs_q <= 1'b0;
    end else if (tick) begin
      cnt  <= '0;
      cs_q <= ~cs_q;
    end else begin
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx -- byte-wide UART transmitter, 8N1 framing, LSB first.
// Parameters:
//   CLK_FREQUENCY  : user_clk frequency in Hz
//   UART_FREQUENCY : baud rate; bit period DIV = CLK_FREQUENCY/UART_FREQUENCY (>= 2)
// Ports:
//   user_clk      : clock, rising edge
//   rst_n         : asynchronous active-low reset, aborts any frame in flight
//   start_tx      : level request; accepted on an edge while idle
//   data          : byte to send, captured on the acceptance edge
//   tx_bit        : registered serial line, idle high
//   ready         : high only while idle
//   chipscope_clk : debug clock toggling once per bit period, 0 when idle
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// between data[7] and the stop bit (11-bit frame).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY  = 125000000,
  parameter int unsigned UART_FREQUENCY = 9600
) (
  input  logic       user_clk,
  input  logic       rst_n,
  input  logic       start_tx,
  input  logic [7:0] data,
  output logic       tx_bit,
  output logic       ready,
  output logic       chipscope_clk
);

  localparam int unsigned DIV = CLK_FREQUENCY / UART_FREQUENCY;

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  // Position of the bit currently on the line: 0 = start, 1..8 = data.
  logic [3:0]           bit_pos;
  logic                 tick;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  assign ready = (state == ST_IDLE);

  uart_baud_gen #(
    .DIV (DIV)
  ) u_baud_gen (
    .clk           (user_clk),
    .rst_n         (rst_n),
    .en            (state != ST_IDLE),
    .tick          (tick),
    .chipscope_clk (chipscope_clk)
  );

  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      tx_bit  <= 1'b1;
      shreg   <= '0;
      bit_pos <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_tx) begin
            state   <= ST_START;
            tx_bit  <= 1'b0;
            shreg   <= data;
            bit_pos <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= even_parity(data);
`endif
          end
        end

        ST_START: begin
          if (tick) begin
            state   <= ST_DATA;
            tx_bit  <= shreg[0];
            shreg   <= shreg >> 1;
            bit_pos <= bit_pos + 4'd1;
          end
        end

        ST_DATA: begin
          if (tick) begin
            bit_pos <= bit_pos + 4'd1;
            if (bit_pos == 4'(DATA_BITS)) begin
`ifdef UART_TX_PARITY_EN
              state  <= ST_PARITY;
              tx_bit <= parity_q;
`else
              state  <= ST_STOP;
              tx_bit <= 1'b1;
`endif
            end else begin
              tx_bit <= shreg[0];
              shreg  <= shreg >> 1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            state   <= ST_STOP;
            tx_bit  <= 1'b1;
            bit_pos <= bit_pos + 4'd1;
          end
        end
`endif

        ST_STOP: begin
          // The stop bit is always the last frame position.
          if (tick && (bit_pos == 4'(FRAME_BITS - 1))) begin
            state   <= ST_IDLE;
            bit_pos <= '0;
          end
        end

        default: begin
          state  <= ST_IDLE;
          tx_bit <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed bench for uart_tx at DIV = 10 (100 Hz clock, 10 baud).
// Expected bytes are queued when a request is driven; each frame is decoded
// cycle by cycle off the line and compared against the queued byte.
// Honours UART_TX_PARITY_EN when the bundle is built with it.
module tb_uart_tx;

  localparam int unsigned CLK_F  = 100;
  localparam int unsigned UART_F = 10;
  localparam int unsigned DIV    = 10;

  logic       user_clk = 1'b0;
  logic       rst_n    = 1'b0;
  logic       start_tx = 1'b0;
  logic [7:0] data     = 8'h00;
  logic       tx_bit;
  logic       ready;
  logic       chipscope_clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  uart_tx #(
    .CLK_FREQUENCY  (CLK_F),
    .UART_FREQUENCY (UART_F)
  ) dut (
    .user_clk      (user_clk),
    .rst_n         (rst_n),
    .start_tx      (start_tx),
    .data          (data),
    .tx_bit        (tx_bit),
    .ready         (ready),
    .chipscope_clk (chipscope_clk)
  );

  always #5 user_clk = ~user_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts cycles where the line is not idle (tx_bit low or ready low).
  task automatic watch_idle(input string tag, input int cycles);
    int act;
    act = 0;
    for (int i = 0; i < cycles; i++) begin
      if (tx_bit !== 1'b1 || ready !== 1'b1 || chipscope_clk !== 1'b0) act++;
      step();
    end
    chk(tag, act, 0);
  endtask

  // Waits for acceptance, then checks every cycle of the frame against the
  // byte at the head of the scoreboard. Call with the request already driven.
  task automatic check_frame(input string tag, input bit release_req,
                             input bit disturb, output int waited);
    logic [7:0]  b;
    logic [10:0] line;
    logic [31:0] obs;
    int          nbits;
    int          w;
    int          rdy_bad;
    int          cs_bad;
`ifdef UART_TX_PARITY_EN
    nbits = 11;
`else
    nbits = 10;
`endif
    waited = -1;
    chk({tag, "_sb"}, 32'(sb.size() != 0), 1);
    if (sb.size() == 0) return;
    b = sb.pop_front();
    line = '1;
    line[0] = 1'b0;
    for (int i = 0; i < 8; i++) line[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    line[9] = ^b;
`endif
    w = 0;
    while (ready !== 1'b0 && w < 50) begin
      step();
      w++;
    end
    waited = w;
    chk({tag, "_accept"}, 32'(ready), 0);
    if (ready !== 1'b0) return;
    if (release_req) start_tx = 1'b0;
    rdy_bad = 0;
    cs_bad  = 0;
    for (int k = 0; k < nbits; k++) begin
      obs = 32'(line[k]);
      for (int c = 0; c < int'(DIV); c++) begin
        if (tx_bit !== line[k]) obs = 32'(tx_bit);
        if (ready !== 1'b0) rdy_bad++;
        if (chipscope_clk !== 1'(k % 2)) cs_bad++;
        if (disturb && k == 4 && c == 0) begin
          data     = 8'hFF;
          start_tx = 1'b1;
        end
        if (disturb && k == 4 && c == 1) start_tx = 1'b0;
        step();
      end
      chk($sformatf("%s_bit%0d", tag, k), obs, 32'(line[k]));
    end
    chk({tag, "_ready_low"}, rdy_bad, 0);
    chk({tag, "_chipscope"}, cs_bad, 0);
    chk({tag, "_end_ready"}, 32'(ready), 1);
    chk({tag, "_end_tx"}, 32'(tx_bit), 1);
    chk({tag, "_end_cs"}, 32'(chipscope_clk), 0);
  endtask

  initial begin
    int w;

    // Reset state
    repeat (3) step();
    chk("rst_tx", 32'(tx_bit), 1);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_cs", 32'(chipscope_clk), 0);

    // Request present as reset releases: accepted on the first edge
    rst_n    = 1'b1;
    data     = 8'hA5;
    start_tx = 1'b1;
    sb.push_back(8'hA5);
    check_frame("a5", 1'b1, 1'b0, w);
    chk("a5_first_edge", w, 1);
    watch_idle("a5_quiet", 5);

    // start_tx held: two frames with one idle cycle between them
    data     = 8'h3C;
    start_tx = 1'b1;
    sb.push_back(8'h3C);
    sb.push_back(8'h3C);
    check_frame("b2b0", 1'b0, 1'b0, w);
    check_frame("b2b1", 1'b1, 1'b0, w);
    chk("b2b_gap", w, 1);
    watch_idle("b2b_no_third", 3 * DIV);

    // Data change and re-request mid-frame are ignored
    data     = 8'h5A;
    start_tx = 1'b1;
    sb.push_back(8'h5A);
    check_frame("ign", 1'b1, 1'b1, w);
    watch_idle("ign_no_second", 3 * DIV);

    // Reset in the middle of data bit 3 aborts the frame
    data     = 8'hC3;
    start_tx = 1'b1;
    step();
    start_tx = 1'b0;
    chk("abort_accept", 32'(ready), 0);
    repeat (4 * DIV + 3) step();
    chk("abort_pre_tx", 32'(tx_bit), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_tx", 32'(tx_bit), 1);
    chk("abort_ready", 32'(ready), 1);
    chk("abort_cs", 32'(chipscope_clk), 0);
    step();
    step();
    rst_n = 1'b1;
    watch_idle("abort_no_resume", 3 * DIV);

    // MSB-only byte (parity bit 1 when parity is built in)
    data     = 8'h80;
    start_tx = 1'b1;
    sb.push_back(8'h80);
    check_frame("x80", 1'b1, 1'b0, w);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
